vga_source_sequencer: RTL

Frame-synchronous controller that shares the 1-bit-per-colour VGA output between several pattern generators and sequences display bring-up after the pixel PLL locks. It sits between the PLL/timing generator and the VGA pins. It holds the timing generator off until the pixel clock is stable, then selects one pattern source at a time and switches sources only at frame boundaries, so no frame is ever torn.

---
 rtl/vga_seq_pkg.sv | 14 +
 rtl/lock_settle.sv | 30 +++
 rtl/vga_source_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA source sequencer.
// Holds the sequencer state encoding and the blanked colour value.
package vga_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SYNC      = 2'd1,
        S_RUN       = 2'd2
    } seq_state_t;

    localparam int          RGB_W     = 3;
    localparam logic [2:0]  RGB_BLACK = 3'b000;

endpackage

// File: rtl/lock_settle.sv
// Counts consecutive locked pixel-clock cycles and reports a settled level.
// The count saturates once it reaches the last settle cycle.
module lock_settle #(
    parameter int LOCK_SETTLE_CYC = 1024
) (
    input  logic clk_pix,
    input  logic btn_rst,
    input  logic clk_locked,
    output logic settled
);

    localparam int CNT_W = (LOCK_SETTLE_CYC > 1) ? $clog2(LOCK_SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_SETTLE_CYC - 1);

    logic [CNT_W-1:0] r_count;

    // Any unlocked cycle restarts the settle window from zero.
    always_ff @(posedge clk_pix) begin
        if (btn_rst) begin
            r_count <= '0;
        end else if (!clk_locked) begin
            r_count <= '0;
        end else if (r_count != CNT_LAST) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign settled = clk_locked && (r_count == CNT_LAST);

endmodule

// File: rtl/vga_source_sequencer.sv
// Brings up VGA timing after PLL lock and switches pattern sources only at frame starts.
// Optional macro VGA_SEQ_AUTO_ADVANCE_EN adds a per-source frame hold counter.
module vga_source_sequencer
    import vga_seq_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int LOCK_SETTLE_CYC = 1024,
    parameter int HOLD_FRAMES     = 300
) (
    input  logic                       clk_pix,
    input  logic                       btn_rst,
    input  logic                       clk_locked,
    input  logic                       btn_next,
    input  logic                       frame_start,
    input  logic                       de,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic [3*N_SRC-1:0]         src_rgb,
    output logic                       timing_en,
    output logic [$clog2(N_SRC)-1:0]   src_sel,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic                       vga_r,
    output logic                       vga_g,
    output logic                       vga_b
);

    localparam int SEL_W = $clog2(N_SRC);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);

    seq_state_t         r_state;
    logic               r_timing_en;
    logic [SEL_W-1:0]   r_src_sel;
    logic               r_pending;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_hsync;
    logic               r_vsync;

    logic               w_settled;
    logic               w_expire;
    logic               w_advance;
    logic [SEL_W-1:0]   w_sel_inc;
    logic [SEL_W-1:0]   w_sel_next;
    logic [SEL_W-1:0]   w_disp_sel;
    logic [RGB_W-1:0]   w_src_pix;
    logic [RGB_W-1:0]   w_pix;

    lock_settle #(
        .LOCK_SETTLE_CYC (LOCK_SETTLE_CYC)
    ) u_lock_settle (
        .clk_pix    (clk_pix),
        .btn_rst    (btn_rst),
        .clk_locked (clk_locked),
        .settled    (w_settled)
    );

`ifdef VGA_SEQ_AUTO_ADVANCE_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    logic [HOLD_W-1:0]  r_hold;

    // Frames shown on the current source; cleared whenever the source changes.
    always_ff @(posedge clk_pix) begin
        if (btn_rst) begin
            r_hold <= '0;
        end else if ((r_state == S_RUN) && clk_locked && frame_start) begin
            r_hold <= w_advance ? '0 : r_hold + HOLD_W'(1);
        end
    end

    assign w_expire = (r_state == S_RUN) && frame_start && (r_hold == HOLD_LAST);
`else
    assign w_expire = 1'b0;
`endif

    // A request in the frame-start cycle itself still counts for this boundary.
    assign w_advance = (r_state == S_RUN) && clk_locked && frame_start &&
                       (r_pending || btn_next || w_expire);
    assign w_sel_inc  = (r_src_sel == SEL_LAST) ? '0 : r_src_sel + SEL_W'(1);
    assign w_sel_next = w_advance ? w_sel_inc : r_src_sel;
    assign w_disp_sel = (r_state == S_RUN) ? w_sel_next : r_src_sel;

    always_comb begin
        w_src_pix = RGB_BLACK;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_disp_sel == SEL_W'(k)) begin
                w_src_pix = src_rgb[3*k +: 3];
            end
        end
    end

    assign w_pix = w_src_pix & {RGB_W{de}};

    // Sequencer FSM; outputs are registered so the pins see one cycle of latency.
    always_ff @(posedge clk_pix) begin
        if (btn_rst) begin
            r_state     <= S_WAIT_LOCK;
            r_timing_en <= 1'b0;
            r_src_sel   <= '0;
            r_pending   <= 1'b0;
            r_rgb       <= RGB_BLACK;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
        end else if (!clk_locked) begin
            r_state     <= S_WAIT_LOCK;
            r_timing_en <= 1'b0;
            r_pending   <= 1'b0;
            r_rgb       <= RGB_BLACK;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
        end else begin
            unique case (r_state)
                S_WAIT_LOCK: begin
                    r_pending <= 1'b0;
                    r_rgb     <= RGB_BLACK;
                    if (w_settled) begin
                        r_state     <= S_SYNC;
                        r_timing_en <= 1'b1;
                        r_hsync     <= hsync_in;
                        r_vsync     <= vsync_in;
                    end else begin
                        r_timing_en <= 1'b0;
                        r_hsync     <= 1'b1;
                        r_vsync     <= 1'b1;
                    end
                end
                S_SYNC: begin
                    r_timing_en <= 1'b1;
                    r_pending   <= 1'b0;
                    r_hsync     <= hsync_in;
                    r_vsync     <= vsync_in;
                    if (frame_start) begin
                        r_state <= S_RUN;
                        r_rgb   <= w_pix;
                    end else begin
                        r_rgb   <= RGB_BLACK;
                    end
                end
                S_RUN: begin
                    r_timing_en <= 1'b1;
                    r_hsync     <= hsync_in;
                    r_vsync     <= vsync_in;
                    r_rgb       <= w_pix;
                    r_src_sel   <= w_sel_next;
                    if (frame_start) begin
                        r_pending <= 1'b0;
                    end else if (btn_next || w_expire) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_WAIT_LOCK;
                    r_timing_en <= 1'b0;
                    r_pending   <= 1'b0;
                    r_rgb       <= RGB_BLACK;
                    r_hsync     <= 1'b1;
                    r_vsync     <= 1'b1;
                end
            endcase
        end
    end

    assign timing_en = r_timing_en;
    assign src_sel   = r_src_sel;
    assign vga_hsync = r_hsync;
    assign vga_vsync = r_vsync;
    assign vga_r     = r_rgb[2];
    assign vga_g     = r_rgb[1];
    assign vga_b     = r_rgb[0];

endmodule
